// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, legal
// oversampling ratios, parity sense and frame geometry.
package uart_rx_pkg;

    localparam int DATA_W = 8;
    localparam int EDGE_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Only these ratios are supported by the sampler's vote window.
    function automatic logic prescale_ok(input logic [5:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and frame bit counter. Counts only while a frame
// is active and wraps the edge index at the latched Prescale-1.
module uart_rx_edge_bit_counter #(
    parameter int EDGE_W = uart_rx_pkg::EDGE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_active,
    input  logic              i_clear,
    input  logic [EDGE_W-1:0] i_last_edge,
    output logic [EDGE_W-1:0] o_edge_count,
    output logic [3:0]        o_bit_count,
    output logic              o_bit_end
);

    logic [EDGE_W-1:0] r_edge;
    logic [3:0]        r_bit;

    assign o_bit_end    = i_active && (r_edge == i_last_edge);
    assign o_edge_count = r_edge;
    assign o_bit_count  = r_bit;

    // Advance the edge index each active cycle; roll into the next bit at bit end.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // pre-edge values, so evaluation order between blocks cannot matter.
        if (rst || !i_active || i_clear) begin
            r_edge <= '0;
            r_bit  <= '0;
        end else if (o_bit_end) begin
            r_edge <= '0;
            r_bit  <= r_bit + 4'd1;
        end else begin
            r_edge <= r_edge + EDGE_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, sampler sequencing,
// LSB-first deserialisation, parity and stop checking, data_valid strobe.
module uart_rx_ctrl #(
    parameter int DATA_W = uart_rx_pkg::DATA_W,
    parameter int EDGE_W = uart_rx_pkg::EDGE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX_IN,
    input  logic [5:0]        Prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              sampled_bit,
    output logic              data_sample_en,
    output logic [EDGE_W-1:0] edge_count,
    output logic [3:0]        bit_count,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              busy
);

    import uart_rx_pkg::*;

    state_t            r_state;
    state_t            w_next;

    // Frame configuration, frozen at start detection.
    logic [EDGE_W-1:0] r_last_edge;
    logic              r_par_en;
    logic              r_par_typ;

    logic [DATA_W-1:0] r_data;
    logic              r_par_err;
    logic              r_stp_err;

    logic              w_active;
    logic              w_bit_end;
    logic [EDGE_W-1:0] w_edge_count;
    logic [3:0]        w_bit_count;

    logic              w_start_det;
    logic              w_shift;
    logic              w_par_chk;
    logic              w_stp_chk;
    logic              w_data_valid;
    logic              w_par_expected;

    assign w_active = (r_state != ST_IDLE);

    uart_rx_edge_bit_counter #(
        .EDGE_W (EDGE_W)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .i_active     (w_active),
        .i_clear      (w_next == ST_IDLE),
        .i_last_edge  (r_last_edge),
        .o_edge_count (w_edge_count),
        .o_bit_count  (w_bit_count),
        .o_bit_end    (w_bit_end)
    );

    // Parity bit the transmitter should have sent for the received byte.
    assign w_par_expected = (r_par_typ == PAR_ODD) ? ~^r_data : ^r_data;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle control strobes; all actions happen at bit end.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch can be inferred.
        w_next       = r_state;
        w_start_det  = 1'b0;
        w_shift      = 1'b0;
        w_par_chk    = 1'b0;
        w_stp_chk    = 1'b0;
        w_data_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // An unsupported ratio keeps the receiver parked.
                if (prescale_ok(Prescale) && !RX_IN) begin
                    w_next      = ST_START;
                    w_start_det = 1'b1;
                end
            end
            ST_START: begin
                // A high start bit at mid-bit is a glitch, not a frame.
                if (w_bit_end) begin
                    w_next = sampled_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift = 1'b1;
                    if (w_bit_count == 4'(DATA_W)) begin
                        w_next = r_par_en ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_par_chk = 1'b1;
                    w_next    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_stp_chk    = 1'b1;
                    w_data_valid = sampled_bit && !r_par_err;
                    w_next       = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Config latch, shift register and sticky error flags.
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset as well, because the
        // received byte and the flags must read 0 straight out of reset.
        if (rst) begin
            r_last_edge <= '0;
            r_par_en    <= 1'b0;
            r_par_typ   <= 1'b0;
            r_data      <= '0;
            r_par_err   <= 1'b0;
            r_stp_err   <= 1'b0;
        end else begin
            if (w_start_det) begin
                r_last_edge <= EDGE_W'(Prescale - 6'd1);
                r_par_en    <= PAR_EN;
                r_par_typ   <= PAR_TYP;
                r_par_err   <= 1'b0;
                r_stp_err   <= 1'b0;
            end
            if (w_shift) begin
                r_data <= {sampled_bit, r_data[DATA_W-1:1]};
            end
            if (w_par_chk) begin
                r_par_err <= (sampled_bit != w_par_expected);
            end
            if (w_stp_chk) begin
                r_stp_err <= ~sampled_bit;
            end
        end
    end

    assign data_sample_en = w_active;
    assign busy           = w_active;
    assign edge_count     = w_edge_count;
    assign bit_count      = w_bit_count;
    assign P_DATA         = r_data;
    assign data_valid     = w_data_valid;
    assign par_err        = r_par_err;
    assign stp_err        = r_stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: the bench acts as line driver and as the
// majority-vote sampler, and scores received bytes against a queue.
module tb_uart_rx_ctrl;

    import uart_rx_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX_IN;
    logic [5:0]  Prescale;
    logic        PAR_EN;
    logic        PAR_TYP;
    logic        sampled_bit;
    logic        data_sample_en;
    logic [4:0]  edge_count;
    logic [3:0]  bit_count;
    logic [7:0]  P_DATA;
    logic        data_valid;
    logic        par_err;
    logic        stp_err;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_valid = 0;
    int          valid_cyc = 0;
    int          frame_start_cyc = 0;
    logic [7:0]  exp_q[$];

    uart_rx_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .RX_IN          (RX_IN),
        .Prescale       (Prescale),
        .PAR_EN         (PAR_EN),
        .PAR_TYP        (PAR_TYP),
        .sampled_bit    (sampled_bit),
        .data_sample_en (data_sample_en),
        .edge_count     (edge_count),
        .bit_count      (bit_count),
        .P_DATA         (P_DATA),
        .data_valid     (data_valid),
        .par_err        (par_err),
        .stp_err        (stp_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every data_valid pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            n_valid++;
            valid_cyc = cyc;
            check("valid_was_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("valid_p_data", 32'(P_DATA), 32'(exp_q.pop_front()));
            end
            check("valid_par_err", 32'(par_err), 32'd0);
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            RX_IN       = 1'b1;
            sampled_bit = 1'b1;
        end
    endtask

    // Drives one frame bit-by-bit, one oversample edge per cycle. The config
    // inputs are scrambled mid-frame to prove they are latched at start.
    task automatic send_frame(input logic [7:0] b, input logic [5:0] p,
                              input logic par_en, input logic par_typ,
                              input logic par_bit, input logic stop_bit,
                              input logic expect_valid, input int abort_bit);
        logic [10:0] bits;
        int          n;
        bits    = '0;
        for (int k = 0; k < 8; k++) bits[1+k] = b[k];
        if (par_en) begin
            bits[9]  = par_bit;
            bits[10] = stop_bit;
            n        = 11;
        end else begin
            bits[9]  = stop_bit;
            n        = 10;
        end
        if (expect_valid) exp_q.push_back(b);
        @(posedge clk); #1;
        Prescale    = p;
        PAR_EN      = par_en;
        PAR_TYP     = par_typ;
        RX_IN       = 1'b0;
        sampled_bit = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int e = 0; e < int'(p); e++) begin
                @(posedge clk); #1;
                if (i == abort_bit) begin
                    rst      = 1'b1;
                    Prescale = 6'd12;
                    RX_IN    = 1'b0;
                    return;
                end
                RX_IN       = bits[i];
                sampled_bit = bits[i];
                if (i == 0 && e == 0) begin
                    frame_start_cyc = cyc;
                    @(negedge clk);
                    check("start_edge_count", 32'(edge_count), 32'd0);
                    check("start_bit_count", 32'(bit_count), 32'd0);
                    check("start_busy", 32'({busy, data_sample_en}), 32'b11);
                    check("start_clears_errs", 32'({par_err, stp_err}), 32'd0);
                end
                if (i == 2 && e == 0) begin
                    Prescale = (p == PRESCALE_8) ? PRESCALE_16 : PRESCALE_8;
                    PAR_EN   = ~par_en;
                    PAR_TYP  = ~par_typ;
                end
                if (i == 4 && e == 3) begin
                    @(negedge clk);
                    check("mid_edge_count", 32'(edge_count), 32'd3);
                    check("mid_bit_count", 32'(bit_count), 32'd4);
                end
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        RX_IN       = 1'b1;
        Prescale    = PRESCALE_8;
        PAR_EN      = 1'b0;
        PAR_TYP     = PAR_EVEN;
        sampled_bit = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({data_sample_en, edge_count, bit_count, P_DATA,
                                    data_valid, par_err, stp_err, busy}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);
        check("idle_after_reset", 32'({busy, data_sample_en}), 32'd0);

        // P=8, no parity, 0xA5: one pulse 79 cycles after the first START cycle.
        send_frame(8'hA5, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1, -1);
        idle(4);
        check("t1_latency", 32'(valid_cyc - frame_start_cyc), 32'd79);
        check("t1_pulses", 32'(n_valid), 32'd1);
        check("t1_p_data", 32'(P_DATA), 32'hA5);
        check("t1_errs", 32'({par_err, stp_err}), 32'd0);
        check("t1_idle", 32'({busy, data_sample_en, edge_count, bit_count}), 32'd0);

        // P=16, even parity, 0x3C: good parity, then bad parity.
        send_frame(8'h3C, PRESCALE_16, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, -1);
        idle(4);
        check("t2_good_pulses", 32'(n_valid), 32'd2);
        check("t2_good_par_err", 32'(par_err), 32'd0);
        send_frame(8'h3C, PRESCALE_16, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b0, -1);
        idle(4);
        check("t2_bad_pulses", 32'(n_valid), 32'd2);
        check("t2_bad_par_err", 32'(par_err), 32'd1);
        check("t2_bad_stp_err", 32'(stp_err), 32'd0);
        check("t2_bad_p_data", 32'(P_DATA), 32'h3C);

        // P=32, odd parity, back-to-back 0x00 and 0xFF.
        send_frame(8'h00, PRESCALE_32, 1'b1, PAR_ODD, 1'b1, 1'b1, 1'b1, -1);
        send_frame(8'hFF, PRESCALE_32, 1'b1, PAR_ODD, 1'b1, 1'b1, 1'b1, -1);
        idle(4);
        check("t3_pulses", 32'(n_valid), 32'd4);
        check("t3_p_data", 32'(P_DATA), 32'hFF);
        check("t3_errs", 32'({par_err, stp_err}), 32'd0);

        // False start: line low for 3 cycles, sampled start bit high.
        @(posedge clk); #1;
        Prescale    = PRESCALE_8;
        PAR_EN      = 1'b0;
        RX_IN       = 1'b0;
        sampled_bit = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (e == 2) RX_IN = 1'b1;
        end
        @(negedge clk);
        check("glitch_busy_at_bit_end", 32'(busy), 32'd1);
        check("glitch_edge_at_bit_end", 32'(edge_count), 32'd7);
        @(posedge clk); #1;
        check("glitch_back_to_idle", 32'({busy, data_sample_en, edge_count, bit_count}), 32'd0);
        check("glitch_no_flags", 32'({par_err, stp_err}), 32'd0);
        idle(4);
        check("glitch_no_pulse", 32'(n_valid), 32'd4);

        // Stop bit 0 on 0x55, then a good frame clears stp_err at its start.
        send_frame(8'h55, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, -1);
        idle(4);
        check("t5_stp_err", 32'(stp_err), 32'd1);
        check("t5_par_err", 32'(par_err), 32'd0);
        check("t5_pulses", 32'(n_valid), 32'd4);
        check("t5_p_data", 32'(P_DATA), 32'h55);
        send_frame(8'h81, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1, -1);
        idle(4);
        check("t5_recover_pulses", 32'(n_valid), 32'd5);
        check("t5_recover_stp_err", 32'(stp_err), 32'd0);
        check("t5_recover_p_data", 32'(P_DATA), 32'h81);

        // Reset during data bit 4, with an unsupported Prescale and RX_IN low.
        send_frame(8'h5A, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0, 4);
        @(posedge clk);
        @(negedge clk);
        check("t6_reset_outputs", 32'({data_sample_en, edge_count, bit_count, P_DATA,
                                       data_valid, par_err, stp_err, busy}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_bad_prescale_en_1", 32'({data_sample_en, busy}), 32'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t6_bad_prescale_en_20", 32'({data_sample_en, busy, edge_count}), 32'd0);
        check("t6_no_pulse", 32'(n_valid), 32'd5);
        @(posedge clk); #1;
        RX_IN    = 1'b1;
        Prescale = PRESCALE_8;
        idle(2);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame-level controller for the UART receiver. It detects the start condition on RX_IN and sequences the oversampling majority-vote sampler by driving its enable and edge count. It consumes the voted bit once per bit period, deserialises the byte, and checks parity and stop. It sits between the RX pin and the sampler on the input side and the system-side consumer on the output side, delivering P_DATA with a one-cycle data_valid strobe.

Parameters:
DATA_W, 8, payload bits per frame
EDGE_W, 5, edge counter width (covers Prescale up to 32)

Ports:
clk  in  1  receiver oversampling clock; the single clock of the block
rst  in  1  synchronous, active-high reset
RX_IN  in  1  serial line, idle high
Prescale  in  6  oversampling ratio; legal values 8, 16, 32
PAR_EN  in  1  1 = frame carries a parity bit
PAR_TYP  in  1  0 = even parity, 1 = odd parity
sampled_bit  in  1  majority-voted bit from sampler; valid at edge_count == Prescale-1
data_sample_en  out  1  sampler enable; high in every state except IDLE
edge_count  out  EDGE_W  oversample edge index within the current bit, 0..Prescale-1
bit_count  out  4  index of the current frame bit: start=0, data 1..8, parity 9, stop 9 or 10
P_DATA  out  DATA_W  received byte, LSB first on the line
data_valid  out  1  one-cycle pulse: P_DATA is a good frame
par_err  out  1  parity mismatch on the last frame
stp_err  out  1  stop bit sampled as 0 on the last frame
busy  out  1  high while a frame is in progress

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. All outputs are 0, including P_DATA, the error flags and the counters. Any in-flight frame is discarded without a data_valid pulse.
- Config latch: Prescale, PAR_EN and PAR_TYP are registered on the IDLE->START transition and held for the whole frame. Changes mid-frame have no effect.
- Unsupported Prescale value: the block stays in IDLE, ignores RX_IN and keeps data_sample_en=0.
- Counters:
  - edge_count increments every cycle outside IDLE.
  - At edge_count == P-1 (latched Prescale minus 1), edge_count wraps to 0 and bit_count increments.
  - Both counters are 0 in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP. A "bit end" is any cycle with edge_count == P-1.
  - IDLE: RX_IN == 0 at posedge -> START. edge_count = 0 in the first START cycle. par_err and stp_err clear on this transition.
  - START, bit end: sampled_bit == 0 -> DATA. sampled_bit == 1 is a false start (glitch) -> IDLE, with no flags and no data_valid.
  - DATA, each bit end: P_DATA <= {sampled_bit, P_DATA[7:1]}. After the 8th data bit: PAR_EN -> PARITY, else -> STOP.
  - PARITY, bit end: expected = ^P_DATA for even, ~^P_DATA for odd. par_err <= (sampled_bit != expected). Next state is STOP regardless.
  - STOP, bit end: stp_err <= ~sampled_bit. data_valid = 1 for exactly this cycle if the frame's parity (when enabled) and stop both pass, with P_DATA already final. Next state is IDLE.
- Back-to-back frames: IDLE is occupied for at least one cycle after STOP. A start edge can be detected in that first IDLE cycle.
- Hold rules:
  - P_DATA holds its value between frames.
  - par_err and stp_err hold until the next start detection or reset.
  - On error, P_DATA still holds the shifted byte, but data_valid stays 0.
- busy = (state != IDLE).
- Frame length in cycles from the first START cycle: (10 + PAR_EN) * P.

Decomposition:
- Shared package uart_rx_pkg:
  - state encoding (IDLE..STOP, 3-bit)
  - PRESCALE_8/16/32 constants
  - PAR_EVEN = 0, PAR_ODD = 1
  - DATA_W
- One sub-module: uart_rx_edge_bit_counter. It holds edge_count and bit_count with enable, the P-1 wrap and a bit_end output. The FSM, shift register and checks stay in uart_rx_ctrl.

Test Plan:
- Prescale = 8, PAR_EN = 0, byte 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) -> data_valid pulses once, 79 cycles after the first START cycle. P_DATA = 0xA5, par_err = stp_err = 0.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 0, byte 0x3C sent with parity bit 0 -> valid, P_DATA = 0x3C. Repeat with parity bit 1 -> par_err = 1 and no data_valid.
- Prescale = 32, PAR_EN = 1, PAR_TYP = 1, two back-to-back frames 0x00 (parity 1) then 0xFF (parity 1), with the next start one cycle after STOP -> two data_valid pulses. P_DATA reads 0x00 then 0xFF.
- Prescale = 8, RX_IN low for 3 cycles then high (sampled_bit = 1 at edge 7) -> return to IDLE at the start-bit end. No flags; data_sample_en drops.
- Prescale = 8, byte 0x55 with stop bit driven 0 -> stp_err = 1, no data_valid. The next good frame clears stp_err on its start.
- Reset asserted at DATA bit 4, plus Prescale = 12 while RX_IN is low -> IDLE and all outputs 0 on the next cycle. With Prescale = 12 the block stays IDLE and data_sample_en stays 0.
